// File: rtl/fb_pkg.sv
// Constants and types shared by the frame-buffer fill writer and the scan-out reader.
// burst_size clips a burst so that it never runs past the remaining words.
package fb_pkg;

  localparam logic [29:0] FB_ADDRESS = 30'h3800_0000;
  localparam int FB_LENGTH = 1536000;
  localparam int AVALON_ADDR_W = 29;
  localparam int AVALON_DATA_W = 64;
  localparam int AVALON_BURST_W = 8;

  typedef enum logic {
    IDLE,
    BURST
  } fb_state_t;

  function automatic logic [AVALON_BURST_W-1:0] burst_size(
    input logic [AVALON_BURST_W-1:0] max_beats,
    input logic [23:0] words
  );
    return (words < {16'd0, max_beats}) ? words[AVALON_BURST_W-1:0] : max_beats;
  endfunction

endpackage

// File: rtl/frame_buffer_fill.sv
// Fills the SDRAM frame buffer with one 32-bit colour using back-to-back Avalon-MM
// burst writes; two pixels per 64-bit beat.
module frame_buffer_fill
  import fb_pkg::*;
#(
  parameter logic [29:0] ADDRESS = FB_ADDRESS,
  parameter int LENGTH = FB_LENGTH,
  parameter int BURST_LENGTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [31:0]               color,
  output logic                      busy,
  output logic                      done,
  output logic [AVALON_ADDR_W-1:0]  address,
  output logic [AVALON_BURST_W-1:0] burstcount,
  output logic [AVALON_DATA_W-1:0]  writedata,
  output logic [7:0]                byteenable,
  output logic                      write,
  input  logic                      waitrequest
);

  localparam logic [23:0] TOTAL_WORDS = 24'(LENGTH / 8);
  localparam logic [AVALON_ADDR_W-1:0] BASE_WORD = AVALON_ADDR_W'(ADDRESS >> 3);
  localparam logic [AVALON_BURST_W-1:0] BURST_MAX = AVALON_BURST_W'(BURST_LENGTH);

  fb_state_t state;
  logic [23:0] words_remaining;
  logic [7:0]  beat_count;
  logic        accepted;

  assign accepted   = write && !waitrequest;
  assign byteenable = 8'hFF;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      write           <= 1'b0;
      address         <= '0;
      burstcount      <= '0;
      writedata       <= '0;
      words_remaining <= '0;
      beat_count      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle still belongs to the finishing fill, so a start there is dropped.
          if (start && !done) begin
            if (TOTAL_WORDS == 24'd0) begin
              done <= 1'b1;
            end else begin
              state           <= BURST;
              busy            <= 1'b1;
              write           <= 1'b1;
              address         <= BASE_WORD;
              words_remaining <= TOTAL_WORDS;
              burstcount      <= burst_size(BURST_MAX, TOTAL_WORDS);
              beat_count      <= '0;
              writedata       <= {color, color};
            end
          end
        end
        BURST: begin
          if (accepted) begin
            words_remaining <= words_remaining - 24'd1;
            if (words_remaining == 24'd1) begin
              state      <= IDLE;
              write      <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              beat_count <= '0;
            end else if (beat_count == burstcount - 8'd1) begin
              // Next burst is set up in the same cycle so write never drops between bursts.
              address    <= address + AVALON_ADDR_W'(burstcount);
              burstcount <= burst_size(BURST_MAX, words_remaining - 24'd1);
              beat_count <= '0;
            end else begin
              beat_count <= beat_count + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_fill.sv
// Directed bench for frame_buffer_fill: two-burst fill, stalls, partial burst,
// ignored starts, mid-fill reset and an empty region.
module tb_frame_buffer_fill;

  localparam logic [28:0] BASE = 29'h0700_0000;

  logic clk = 1'b0;
  logic reset, waitrequest;
  logic [31:0] color;
  logic start_a, start_b, start_z;

  logic busy_a, done_a, write_a;
  logic [28:0] address_a;
  logic [7:0] burstcount_a, byteenable_a;
  logic [63:0] writedata_a;

  logic busy_b, done_b, write_b;
  logic [28:0] address_b;
  logic [7:0] burstcount_b, byteenable_b;
  logic [63:0] writedata_b;

  logic busy_z, done_z, write_z;
  logic [28:0] address_z;
  logic [7:0] burstcount_z, byteenable_z;
  logic [63:0] writedata_z;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  frame_buffer_fill #(.ADDRESS(30'h3800_0000), .LENGTH(128), .BURST_LENGTH(8)) dut_a (
    .clock(clk), .reset(reset), .start(start_a), .color(color),
    .busy(busy_a), .done(done_a), .address(address_a), .burstcount(burstcount_a),
    .writedata(writedata_a), .byteenable(byteenable_a), .write(write_a),
    .waitrequest(waitrequest)
  );

  frame_buffer_fill #(.ADDRESS(30'h3800_0000), .LENGTH(80), .BURST_LENGTH(8)) dut_b (
    .clock(clk), .reset(reset), .start(start_b), .color(color),
    .busy(busy_b), .done(done_b), .address(address_b), .burstcount(burstcount_b),
    .writedata(writedata_b), .byteenable(byteenable_b), .write(write_b),
    .waitrequest(waitrequest)
  );

  frame_buffer_fill #(.ADDRESS(30'h3800_0000), .LENGTH(0), .BURST_LENGTH(8)) dut_z (
    .clock(clk), .reset(reset), .start(start_z), .color(color),
    .busy(busy_z), .done(done_z), .address(address_z), .burstcount(burstcount_z),
    .writedata(writedata_z), .byteenable(byteenable_z), .write(write_z),
    .waitrequest(waitrequest)
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy_a, done_a, write_a} !== 3'b000 || address_a !== 29'd0 ||
        burstcount_a !== 8'd0 || writedata_a !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy/done/write=%b addr=%h bc=%0d data=%h, need 000 0 0 0",
               {busy_a, done_a, write_a}, address_a, burstcount_a, writedata_a);
    end
    vectors++;
    if (byteenable_a !== 8'hFF) begin
      miscompares++;
      $display("FAIL byteenable: got %h, need ff", byteenable_a);
    end
    reset = 1'b0;
    @(negedge clk);
    $display("reset: outputs idle after reset");
  endtask

  task automatic test_basic();
    int beats, dones, done_at;
    beats = 0; dones = 0; done_at = 0;
    waitrequest = 1'b0;
    color = 32'h00FF8040;
    @(negedge clk); start_a = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk); start_a = 1'b0;
      if (write_a) begin
        vectors++;
        if (i != beats + 1 || address_a !== BASE + 29'((beats / 8) * 8) ||
            burstcount_a !== 8'd8 || writedata_a !== 64'h00FF8040_00FF8040) begin
          miscompares++;
          $display("FAIL basic_beat%0d: cycle=%0d addr=%h bc=%0d data=%h, need cycle=%0d addr=%h bc=8 data=00ff804000ff8040",
                   beats, i, address_a, burstcount_a, writedata_a, beats + 1,
                   BASE + 29'((beats / 8) * 8));
        end
        beats++;
      end
      if (done_a) begin dones++; done_at = i; end
    end
    vectors++;
    if (beats != 16 || dones != 1 || done_at != 17 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_totals: beats=%0d dones=%0d done_at=%0d busy=%b, need 16 1 17 0",
               beats, dones, done_at, busy_a);
    end
    $display("basic: %0d beats, done at cycle %0d", beats, done_at);
  endtask

  task automatic test_stall();
    int beats, dones;
    logic prev_stall;
    logic [28:0] pa;
    logic [7:0] pb;
    logic [63:0] pd;
    beats = 0; dones = 0; prev_stall = 1'b0;
    pa = '0; pb = '0; pd = '0;
    color = 32'h00FF8040;
    @(negedge clk); start_a = 1'b1; waitrequest = 1'b0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk); start_a = 1'b0;
      if (prev_stall) begin
        vectors++;
        if (write_a !== 1'b1 || address_a !== pa || burstcount_a !== pb || writedata_a !== pd) begin
          miscompares++;
          $display("FAIL stall_hold: cycle=%0d write=%b addr=%h bc=%0d data=%h, need 1 %h %0d %h",
                   i, write_a, address_a, burstcount_a, writedata_a, pa, pb, pd);
        end
      end
      if (done_a) dones++;
      waitrequest = 1'($urandom_range(0, 1));
      prev_stall = write_a && waitrequest;
      pa = address_a; pb = burstcount_a; pd = writedata_a;
      if (write_a && !waitrequest) begin
        vectors++;
        if (address_a !== BASE + 29'((beats / 8) * 8) || burstcount_a !== 8'd8 ||
            writedata_a !== 64'h00FF8040_00FF8040) begin
          miscompares++;
          $display("FAIL stall_beat%0d: addr=%h bc=%0d data=%h, need %h 8 00ff804000ff8040",
                   beats, address_a, burstcount_a, writedata_a, BASE + 29'((beats / 8) * 8));
        end
        beats++;
      end
    end
    waitrequest = 1'b0;
    vectors++;
    if (beats != 16 || dones != 1) begin
      miscompares++;
      $display("FAIL stall_totals: beats=%0d dones=%0d, need 16 1", beats, dones);
    end
    $display("stall: %0d beats accepted, %0d done pulses", beats, dones);
  endtask

  task automatic test_partial();
    int beats, dones, done_at;
    logic [28:0] exp_addr;
    logic [7:0] exp_bc;
    beats = 0; dones = 0; done_at = 0;
    waitrequest = 1'b0;
    color = 32'h00102030;
    @(negedge clk); start_b = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); start_b = 1'b0;
      if (write_b) begin
        exp_addr = (beats < 8) ? BASE : BASE + 29'd8;
        exp_bc = (beats < 8) ? 8'd8 : 8'd2;
        vectors++;
        if (address_b !== exp_addr || burstcount_b !== exp_bc ||
            writedata_b !== 64'h00102030_00102030) begin
          miscompares++;
          $display("FAIL partial_beat%0d: addr=%h bc=%0d data=%h, need %h %0d 0010203000102030",
                   beats, address_b, burstcount_b, writedata_b, exp_addr, exp_bc);
        end
        beats++;
      end
      if (done_b) begin dones++; done_at = i; end
    end
    vectors++;
    if (beats != 10 || dones != 1 || done_at != 11) begin
      miscompares++;
      $display("FAIL partial_totals: beats=%0d dones=%0d done_at=%0d, need 10 1 11",
               beats, dones, done_at);
    end
    $display("partial: %0d beats, done at cycle %0d", beats, done_at);
  endtask

  task automatic test_start_ignored();
    int beats, done_at, k;
    beats = 0; done_at = 0;
    waitrequest = 1'b0;
    color = 32'h00123456;
    @(negedge clk); start_a = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk); start_a = 1'b0;
      if (i == 5) begin start_a = 1'b1; color = 32'h0; end
      if (write_a) begin
        vectors++;
        if (writedata_a !== 64'h00123456_00123456) begin
          miscompares++;
          $display("FAIL ignore_data%0d: got %h, need 0012345600123456", beats, writedata_a);
        end
        beats++;
      end
      if (done_a) begin done_at = i; break; end
    end
    vectors++;
    if (beats != 16 || done_at != 17) begin
      miscompares++;
      $display("FAIL ignore_totals: beats=%0d done_at=%0d, need 16 17", beats, done_at);
    end
    // start held across the done cycle: dropped there, taken on the next one
    start_a = 1'b1; color = 32'h00ABCDEF;
    @(negedge clk);
    vectors++;
    if (busy_a !== 1'b0 || write_a !== 1'b0) begin
      miscompares++;
      $display("FAIL start_on_done: busy=%b write=%b, need 0 0", busy_a, write_a);
    end
    @(negedge clk); start_a = 1'b0;
    vectors++;
    if (busy_a !== 1'b1 || write_a !== 1'b1 || address_a !== BASE ||
        writedata_a !== 64'h00ABCDEF_00ABCDEF) begin
      miscompares++;
      $display("FAIL start_after_done: busy=%b write=%b addr=%h data=%h, need 1 1 %h 00abcdef00abcdef",
               busy_a, write_a, address_a, writedata_a, BASE);
    end
    k = 0;
    while (!done_a && k < 40) begin @(negedge clk); k++; end
    vectors++;
    if (done_a !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_done: done=%b after %0d cycles, need 1", done_a, k);
    end
    $display("start_ignored: %0d beats, restart finished after %0d cycles", beats, k);
  endtask

  task automatic test_reset_mid();
    int beats, k;
    beats = 0;
    waitrequest = 1'b0;
    color = 32'h00C0FFEE;
    @(negedge clk); start_a = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); start_a = 1'b0;
      if (write_a) beats++;
      if (beats == 3) begin reset = 1'b1; break; end
    end
    @(negedge clk); reset = 1'b0;
    vectors++;
    if (beats != 3 || write_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: beats=%0d write=%b busy=%b done=%b, need 3 0 0 0",
               beats, write_a, busy_a, done_a);
    end
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    vectors++;
    if (write_a !== 1'b1 || address_a !== BASE || burstcount_a !== 8'd8 ||
        writedata_a !== 64'h00C0FFEE_00C0FFEE) begin
      miscompares++;
      $display("FAIL reset_restart: write=%b addr=%h bc=%0d data=%h, need 1 %h 8 00c0ffee00c0ffee",
               write_a, address_a, burstcount_a, writedata_a, BASE);
    end
    k = 0;
    while (!done_a && k < 40) begin @(negedge clk); k++; end
    vectors++;
    if (done_a !== 1'b1 || k != 16) begin
      miscompares++;
      $display("FAIL reset_drain: done=%b cycles=%0d, need 1 16", done_a, k);
    end
    $display("reset_mid: reset after %0d beats, refill done after %0d cycles", beats, k);
  endtask

  task automatic test_zero();
    @(negedge clk); start_z = 1'b1;
    @(negedge clk); start_z = 1'b0;
    vectors++;
    if (done_z !== 1'b1 || busy_z !== 1'b0 || write_z !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len: done=%b busy=%b write=%b, need 1 0 0", done_z, busy_z, write_z);
    end
    @(negedge clk);
    vectors++;
    if (done_z !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_pulse: done=%b, need 0", done_z);
    end
    $display("zero: empty region completes immediately");
  endtask

  initial begin
    reset = 1'b1; waitrequest = 1'b0; color = 32'h0;
    start_a = 1'b0; start_b = 1'b0; start_z = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_partial();
    test_start_ignored();
    test_reset_mid();
    test_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
